// File: rtl/f1_delay_timer.sv
// Random-hold timer for the F1 start lights: loads MIN_DELAY plus LFSR bits on start and counts ticks down.
// Define F1_FIXED_DELAY_EN to replace the random offset with FIXED_OFFSET for deterministic bring-up holds.
module f1_delay_timer #(
  parameter int unsigned       LFSR_W       = 16,
  parameter logic [LFSR_W-1:0] SEED         = 16'hACE1,
  parameter int unsigned       RANGE_W      = 11,
  parameter int unsigned       MIN_DELAY    = 250,
  parameter int unsigned       FIXED_OFFSET = 500,
  parameter int unsigned       CNT_W        = 12
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             en_lfsr,
  input  logic             start_delay,
  input  logic             abort,
  output logic             time_out,
  output logic             busy,
  output logic [CNT_W-1:0] delay_ms,
  output logic [CNT_W-1:0] remaining
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [LFSR_W-1:0] SeedEff  = (SEED == '0) ? LFSR_W'(1) : SEED;
  localparam logic [CNT_W-1:0]  MinDelay = CNT_W'(MIN_DELAY);

  state_e             state_q, state_d;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic [CNT_W-1:0]   delay_q, delay_d;
  logic [CNT_W-1:0]   load_val;
  logic               feedback;

`ifdef F1_FIXED_DELAY_EN
  localparam logic [RANGE_W-1:0] FixedOffset = RANGE_W'(FIXED_OFFSET);
  assign load_val = MinDelay + {{(CNT_W-RANGE_W){1'b0}}, FixedOffset};
`else
  assign load_val = MinDelay + {{(CNT_W-RANGE_W){1'b0}}, lfsr_q[RANGE_W-1:0]};
`endif

  // Fibonacci taps for x^16+x^14+x^13+x^11+1; shifts in every state.
  assign feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign lfsr_d   = en_lfsr ? {lfsr_q[LFSR_W-2:0], feedback} : lfsr_q;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lfsr_q      <= SeedEff;
      remaining_q <= '0;
      delay_q     <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      remaining_q <= remaining_d;
      delay_q     <= delay_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    delay_d     = delay_q;
    case (state_q)
      IDLE: begin
        if (start_delay && !abort) begin
          delay_d     = load_val;
          remaining_d = load_val;
          state_d     = (load_val == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          remaining_d = '0;
          state_d     = IDLE;
        end else if (tick) begin
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == RUN);
    time_out = (state_q == DONE);
  end

  assign delay_ms  = delay_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_f1_delay_timer.sv
// Scoreboard bench for f1_delay_timer: stimulus pushes the cycle at which time_out is due,
// a monitor pops and compares on every time_out pulse.
module tb_f1_delay_timer;

`ifdef F1_FIXED_DELAY_EN
  localparam int DSEED  = 750;
  localparam int DSHIFT = 750;
`else
  localparam int DSEED  = 1499;
  localparam int DSHIFT = 701;
`endif

  logic        sysclk = 1'b0;
  logic        rst_n = 1'b1;
  logic        tick = 1'b0;
  logic        en_lfsr = 1'b0;
  logic        start_delay = 1'b0;
  logic        abort = 1'b0;
  logic        time_out;
  logic        busy;
  logic [11:0] delay_ms;
  logic [11:0] remaining;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int toCount = 0;
  int expQ[$];

  f1_delay_timer dut (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .tick        (tick),
    .en_lfsr     (en_lfsr),
    .start_delay (start_delay),
    .abort       (abort),
    .time_out    (time_out),
    .busy        (busy),
    .delay_ms    (delay_ms),
    .remaining   (remaining)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Every time_out must match the oldest outstanding expiry.
  always @(negedge sysclk) begin
    if (rst_n && time_out) begin
      toCount++;
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_time_out: got time_out=1 at cycle %0d, required none", cyc);
      end else begin
        checkOutput("expiry_cycle", cyc, expQ.pop_front());
      end
      checkOutput("busy_at_timeout", int'(busy), 0);
      checkOutput("remaining_at_timeout", int'(remaining), 0);
    end
  end

  task automatic cycle();
    @(posedge sysclk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic t, input logic e, input logic a);
    start_delay = s;
    tick        = t;
    en_lfsr     = e;
    abort       = a;
    cycle();
  endtask

  task automatic runTicks(input int n, input int gap, input logic e);
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b0, 1'b1, e, 1'b0);
      for (int g = 1; g < gap; g++) applyStimulus(1'b0, 1'b0, e, 1'b0);
    end
  endtask

  task automatic doReset();
    start_delay = 1'b0;
    tick        = 1'b0;
    en_lfsr     = 1'b0;
    abort       = 1'b0;
    #2 rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  initial begin
    int loadCyc;
    int toBefore;

    // Reset values and the seed-based hold with ticks every cycle.
    doReset();
    checkOutput("reset_time_out", int'(time_out), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_delay_ms", int'(delay_ms), 0);
    checkOutput("reset_remaining", int'(remaining), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    loadCyc = cyc;
    expQ.push_back(loadCyc + DSEED);
    checkOutput("seed_delay_ms", int'(delay_ms), DSEED);
    checkOutput("seed_busy", int'(busy), 1);
    checkOutput("seed_remaining", int'(remaining), DSEED);
    runTicks(DSEED - 1, 1, 1'b0);
    checkOutput("seed_last_remaining", int'(remaining), 1);
    checkOutput("seed_busy_before_expiry", int'(busy), 1);
    runTicks(1, 1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("seed_delay_ms_held", int'(delay_ms), DSEED);

    // One LFSR shift, then sparse ticks every second cycle.
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    loadCyc = cyc;
    expQ.push_back(loadCyc + 1 + (DSHIFT - 1) * 2);
    checkOutput("shift_delay_ms", int'(delay_ms), DSHIFT);
    runTicks(DSHIFT, 2, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Abort after ten ticks, then abort beating start in IDLE.
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runTicks(10, 1, 1'b0);
    checkOutput("abort_pre_remaining", int'(remaining), DSEED - 10);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_remaining", int'(remaining), 0);
    checkOutput("abort_delay_ms_held", int'(delay_ms), DSEED);
    toBefore = toCount;
    runTicks(2000, 1, 1'b0);
    checkOutput("abort_no_time_out", toCount - toBefore, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("abort_priority_busy", int'(busy), 0);
    checkOutput("abort_priority_remaining", int'(remaining), 0);

    // start_delay held high: one expiry, then an immediate reload from the shifted LFSR.
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    loadCyc = cyc;
    checkOutput("held_remaining_same_cycle_tick", int'(remaining), DSEED);
    expQ.push_back(loadCyc + DSEED);
    expQ.push_back(loadCyc + DSEED + 2 + DSHIFT);
    for (int i = 1; i <= DSEED + 2 + DSHIFT; i++) begin
      applyStimulus(1'b1, 1'b1, (i == 100), 1'b0);
      if (i == DSEED + 1) checkOutput("held_idle_after_done", int'(busy), 0);
      if (i == DSEED + 2) begin
        checkOutput("held_reload_delay_ms", int'(delay_ms), DSHIFT);
        checkOutput("held_reload_busy", int'(busy), 1);
      end
    end
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("held_final_busy", int'(busy), 0);

    // Reset mid-run with the LFSR moving, then confirm the seed is restored.
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("pre_shift_load", int'(delay_ms), DSEED);
    runTicks(DSEED - 300, 1, 1'b1);
    checkOutput("midrun_remaining", int'(remaining), 300);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrun_rst_time_out", int'(time_out), 0);
    checkOutput("midrun_rst_busy", int'(busy), 0);
    checkOutput("midrun_rst_delay_ms", int'(delay_ms), 0);
    checkOutput("midrun_rst_remaining", int'(remaining), 0);
    rst_n = 1'b1;
    toBefore = toCount;
    runTicks(400, 1, 1'b0);
    checkOutput("midrun_no_time_out", toCount - toBefore, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("seed_restored_delay_ms", int'(delay_ms), DSEED);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    checkOutput("outstanding_expiries", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/f1_delay_timer.md
# f1_delay_timer

Random-hold timer for the F1 starting-light controller. Sits directly downstream of the light-sequence FSM. It keeps a free-running 16-bit LFSR advancing while `en_lfsr` is high. On `start_delay` it loads a pseudo-random millisecond count and counts it down on `tick`. At expiry it returns a one-cycle `time_out` pulse to the FSM, which then extinguishes the lights.

## Interface
- `LFSR_W`, 16: LFSR width. The tap set below is fixed for 16.
- `SEED`, 16'hACE1: LFSR reset value. A value of 0 is illegal; the implementation substitutes 1.
- `RANGE_W`, 11: number of LFSR low bits used as the random offset (0..2047 ms).
- `MIN_DELAY`, 250: fixed minimum hold in ms.
- `FIXED_OFFSET`, 500: offset used only when `F1_FIXED_DELAY_EN` is defined.
- `CNT_W`, 12: counter width. Must satisfy MIN_DELAY + 2^RANGE_W − 1 < 2^CNT_W.
- `sysclk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `tick`  in  1  1 ms strobe, one `sysclk` cycle wide.
- `en_lfsr`  in  1  LFSR advances on every `sysclk` cycle this is high.
- `start_delay`  in  1  start request, sampled only in IDLE.
- `abort`  in  1  synchronous cancel.
- `time_out`  out  1  one-cycle expiry pulse.
- `busy`  out  1  high while counting.
- `delay_ms`  out  CNT_W  hold value captured at the last start.
- `remaining`  out  CNT_W  current countdown value.

## Operation
- LFSR is Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Update: lfsr ← {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - It shifts whenever `en_lfsr`=1, in any state, and holds otherwise.
- Loaded value = MIN_DELAY + lfsr[RANGE_W-1:0].
  - Unsigned, zero-extended to CNT_W. No overflow by parameter rule.
  - Uses the LFSR value before any shift in the same cycle.
- States are IDLE, RUN and DONE.
- IDLE:
  - `start_delay`=1 and `abort`=0 → load `remaining` and `delay_ms`, then go to RUN.
  - If the loaded value is 0, go directly to DONE.
- RUN:
  - `abort`=1 → IDLE, with `remaining` cleared and no `time_out`.
  - Else, on `tick`: `remaining` decrements. When `remaining`==1 it becomes 0 and the next state is DONE.
- DONE: `time_out`=1 for this single cycle, then IDLE unconditionally. `abort` is ignored here.
- `start_delay` in RUN or DONE is ignored and not queued.
- `abort` has priority over `start_delay` in IDLE; nothing is loaded.
- A `tick` in the same cycle as the start is not counted.

## Timing
- Reset values: state IDLE, lfsr SEED, `time_out` 0, `busy` 0, `delay_ms` 0, `remaining` 0.
- Reset mid-RUN aborts immediately with no `time_out`.
- All outputs are registered (Moore).
- `busy` is high exactly while in RUN.
- `time_out` is high exactly while in DONE.
- Latency: with loaded value N≥1, `time_out` asserts the cycle after the N-th `tick` following the load cycle.
- `busy` falls on the same edge that `time_out` rises.
- `delay_ms` holds its value until the next accepted start.
- `remaining` reads 0 after expiry or abort.

## Configuration
- `F1_FIXED_DELAY_EN` defined:
  - Loaded value = MIN_DELAY + FIXED_OFFSET[RANGE_W-1:0], giving deterministic holds for bring-up.
  - The LFSR still shifts per `en_lfsr` but does not affect the delay.
- Undefined: random load as described in Operation.

## Test plan
- Reset, then `en_lfsr`=0 and `start_delay` pulse:
  - `delay_ms`=1499 (250+0x4E1) and `busy`=1.
  - `time_out` pulses once, one cycle after the 1499th `tick`.
  - `busy` falls on that same edge.
- Reset, `en_lfsr`=1 for one cycle, then start:
  - lfsr=0x59C3 and `delay_ms`=701.
  - Expiry after 701 ticks.
- Abort after 10 ticks in RUN:
  - Next cycle `busy`=0 and `remaining`=0.
  - No `time_out` for the following 2000 ticks.
- `start_delay` held high throughout a run:
  - Exactly one `time_out`.
  - A new load occurs on the first IDLE cycle after DONE.
- Reset asserted mid-RUN (`remaining`=300):
  - All outputs 0 immediately and lfsr=0xACE1.
  - No `time_out` after release.
- `F1_FIXED_DELAY_EN` defined, any LFSR state:
  - `delay_ms`=750 and expiry after 750 ticks.
